fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Shares the single framebuffer write FIFO among NUM_REQ pixel-write requesters
//  (brush, screen-clear engine, line/fill engine).
//  Round-robin grant; a grant holds for a burst of beats.
//  Emits registered push/x/y/rgb toward the FIFO, honouring fifofull and the memory-enable window.
// PARAMETERS
//  NUM_REQ     3    number of requesters (2..8)
//  HPOS_WIDTH  10   x coordinate width
//  VPOS_WIDTH  9    y coordinate width
//  MAX_BURST   64   max beats per grant before forced release (>=1)
// PORTS
//  clk        in   1               clock
//  reset      in   1               asynchronous, active-high
//  mem_en     in   1               write window open; low = no grant, no transfer
//  req_valid  in   NUM_REQ         requester i has a pixel
//  req_last   in   NUM_REQ         current beat of i ends its burst
//  req_x      in   NUM_REQ*HPOS_W  packed x, slice i = [i*HPOS_WIDTH +: HPOS_WIDTH]
//  req_y      in   NUM_REQ*VPOS_W  packed y, same packing
//  req_rgb    in   NUM_REQ*3       packed colour
//  req_ready  out  NUM_REQ         beat of i accepted this cycle (valid&ready)
//  fifofull   in   1               FIFO almost-full: asserted with >=1 free entry left
//  fifopush   out  1               write strobe to FIFO
//  wr_x       out  HPOS_WIDTH      pixel x to FIFO
//  wr_y       out  VPOS_WIDTH      pixel y to FIFO
//  wr_rgb     out  3               pixel colour to FIFO
//  grant_id   out  $clog2(NUM_REQ) current/last granted requester
//  busy       out  1               state==BURST
// BEHAVIOUR
//  Reset: state=IDLE, fifopush=0, wr_x=wr_y=wr_rgb=0, grant_id=0, rr_ptr=NUM_REQ-1, beat_cnt=0.
//  Reset mid-burst: burst dropped, no further push; in-flight beat lost.
//  States:
//  - IDLE: if mem_en & |req_valid, grant = first valid index searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ);
//    -> BURST next cycle, beat_cnt=0. req_ready all 0 in IDLE.
//  - BURST: req_ready[g] = req_valid[g] & mem_en & ~fifofull (combinational); all others 0.
//  Transfer (valid&ready):
//  - next cycle fifopush=1 and wr_* = req_*[g] (1-cycle latency); beat_cnt++.
//  - no transfer -> fifopush=0 next cycle; wr_* hold.
//  Release BURST -> IDLE, with rr_ptr<=g, on any of:
//  - transfer with req_last[g];
//  - transfer where beat_cnt reaches MAX_BURST-1 (i.e. MAX_BURST beats done);
//  - req_valid[g]=0 in a BURST cycle.
//  No release on fifofull or mem_en=0: burst pauses, beat_cnt holds.
//  IDLE costs 1 cycle per re-arbitration; a sole requester gets its next burst after that gap.
//  Throughput within a burst is 1 beat/cycle.
//  fifofull is almost-full, so the one registered push after fullness is always absorbed.
//  Ties/simultaneous: several valid in IDLE -> round-robin order only; a requester raising valid
//    mid-burst waits for release.
//  beat_cnt width $clog2(MAX_BURST+1); no wrap because release precedes overflow.
//  grant_id holds after release until next grant.
// TESTING
//  1) Single req0: 5 beats, last on 5th, x=10..14 -> fifopush high 5 cycles, one cycle after each ready;
//     wr_x 10..14; then IDLE.
//  2) req0,req1,req2 all valid, continuous, MAX_BURST=4 -> bursts 0,1,2,0,... of 4 beats each,
//     1 idle cycle between.
//  3) fifofull asserted 3 cycles mid-burst -> req_ready=0 and fifopush=0 for those 3 cycles;
//     burst resumes with same grant and beat_cnt.
//  4) mem_en low 2 cycles in BURST, then high -> no pushes during low; no release; remaining beats delivered.
//  5) req1 drops valid after 2 beats while req2 waits -> release after beat 2; req2 granted (rr from 1).
//  6) reset pulsed mid-burst -> next cycle fifopush=0, busy=0, wr_*=0; after reset, arbitration restarts at req0.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Shares the framebuffer write FIFO among NUM_REQ pixel-write requesters
//   (brush, screen-clear engine, line/fill engine). Requesters are granted in
//   round-robin order. A grant is held for a burst of beats. Accepted beats are
//   forwarded to the FIFO as a registered push with x/y/rgb, one cycle later.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   mem_en           write window open; low blocks new grants and transfers
//   req_valid[i]     requester i offers a pixel
//   req_last[i]      the offered beat of i ends its burst
//   req_x/y/rgb      packed per-requester pixel, slice i = [i*W +: W]
//   req_ready[i]     beat of i accepted this cycle (valid & ready)
//   fifofull         FIFO almost-full (at least one entry still free)
//   fifopush         write strobe to the FIFO
//   wr_x/wr_y/wr_rgb pixel written to the FIFO
//   grant_id         current grant, or the last one after release
//   busy             a burst is in progress
module fb_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 9,
  parameter int MAX_BURST  = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mem_en,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*HPOS_WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*VPOS_WIDTH-1:0]   req_y,
  input  logic [NUM_REQ*3-1:0]            req_rgb,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifofull,
  output logic                            fifopush,
  output logic [HPOS_WIDTH-1:0]           wr_x,
  output logic [VPOS_WIDTH-1:0]           wr_y,
  output logic [2:0]                      wr_rgb,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   pick_id;
  logic            pick_vld;
  logic [CW-1:0]   beat_cnt;

  logic                  g_valid;
  logic                  g_last;
  logic                  xfer;
  logic                  release_burst;
  logic                  start_grant;
  logic [HPOS_WIDTH-1:0] sel_x;
  logic [VPOS_WIDTH-1:0] sel_y;
  logic [2:0]            sel_rgb;

  // Round-robin search starting just after ptr. Candidates are scanned from
  // lowest to highest priority so the highest-priority hit is written last.
  // Returns {found, index}.
  function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                          input logic [GW-1:0]      ptr);
    logic [GW:0]   res;
    logic [GW-1:0] ix;
    int            idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      ix  = GW'(idx);
      if (vld[ix]) res = {1'b1, ix};
    end
    return res;
  endfunction

  assign {pick_vld, pick_id} = rr_pick(req_valid, rr_ptr);
  assign busy        = (state == BURST);
  assign start_grant = (state == IDLE) && mem_en && pick_vld;

  // Select the granted requester's beat.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    sel_x   = '0;
    sel_y   = '0;
    sel_rgb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        sel_x   = req_x[i*HPOS_WIDTH +: HPOS_WIDTH];
        sel_y   = req_y[i*VPOS_WIDTH +: VPOS_WIDTH];
        sel_rgb = req_rgb[i*3 +: 3];
      end
    end
  end

  // Next state, handshake and release decision.
  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    xfer          = 1'b0;
    release_burst = 1'b0;
    case (state)
      IDLE: begin
        if (start_grant) state_nxt = BURST;
      end
      BURST: begin
        // fifofull and mem_en only pause the burst; a vanished requester ends it.
        xfer = g_valid && mem_en && !fifofull;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = xfer && (grant_id == GW'(i));
        end
        if (!g_valid || (xfer && (g_last || beat_cnt == CW'(MAX_BURST - 1)))) begin
          release_burst = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Output stage: accepted beat lands on the FIFO interface one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifopush <= 1'b0;
      wr_x     <= '0;
      wr_y     <= '0;
      wr_rgb   <= '0;
      grant_id <= '0;
      rr_ptr   <= GW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      fifopush <= xfer;
      if (xfer) begin
        wr_x     <= sel_x;
        wr_y     <= sel_y;
        wr_rgb   <= sel_rgb;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (start_grant) begin
        grant_id <= pick_id;
        beat_cnt <= '0;
      end
      if (release_burst) rr_ptr <= grant_id;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

  localparam int NR = 3;
  localparam int HW = 10;
  localparam int VW = 9;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_en;
  logic              fifofull;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*HW-1:0]  req_x;
  logic [NR*VW-1:0]  req_y;
  logic [NR*3-1:0]   req_rgb;
  logic              fifopush;
  logic [HW-1:0]     wr_x;
  logic [VW-1:0]     wr_y;
  logic [2:0]        wr_rgb;
  logic [1:0]        grant_id;
  logic              busy;

  int n_run  = 0;
  int n_fail = 0;

  // Requester sources: remaining beats, next x, and "drop valid without last".
  int            rem[NR];
  int            nx[NR];
  int            nolast[NR];
  logic [NR-1:0] rdy_s;

  fb_write_arbiter #(
    .NUM_REQ(NR), .HPOS_WIDTH(HW), .VPOS_WIDTH(VW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en),
    .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_rgb(req_rgb),
    .req_ready(req_ready), .fifofull(fifofull),
    .fifopush(fifopush), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // y = x+3, rgb = x[2:0] for every beat a source offers.
  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = (rem[i] > 0);
      req_last[i]            = (rem[i] == 1) && (nolast[i] == 0);
      req_x[i*HW +: HW]      = HW'(nx[i]);
      req_y[i*VW +: VW]      = VW'(nx[i] + 3);
      req_rgb[i*3 +: 3]      = 3'(nx[i]);
    end
  endtask

  // One clock: capture ready mid-cycle, advance sources after the edge.
  task automatic cycle();
    @(negedge clk);
    rdy_s = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (rdy_s[i]) begin
        rem[i]--;
        nx[i]++;
      end
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    mem_en   = 1'b1;
    fifofull = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; nx[i] = 0; nolast[i] = 0;
    end
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    mem_en   = 1'b1;
    fifofull = 1'b0;
    rem[0] = 3; nx[0] = 5; rem[1] = 0; rem[2] = 0;
    nolast[0] = 0; nolast[1] = 0; nolast[2] = 0;
    drive_inputs();
    @(posedge clk); #1;
    n_run++;
    if ({fifopush, busy, wr_x, wr_y, wr_rgb, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got push=%0b busy=%0b x=%0d y=%0d rgb=%0d gid=%0d, want all 0",
               fifopush, busy, wr_x, wr_y, wr_rgb, grant_id);
    end
    n_run++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    reset  = 1'b0;
    mem_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_run++;
      if (busy !== 1'b0 || fifopush !== 1'b0 || rdy_s !== 3'b000) begin
        n_fail++;
        $display("FAIL memen_idle cyc %0d: busy=%0b push=%0b rdy=%b, want 0 0 000",
                 k, busy, fifopush, rdy_s);
      end
    end
    mem_en = 1'b1;
  endtask

  // Five beats from req0 with MAX_BURST=4: forced release after the fourth,
  // one idle cycle, then the fifth beat in a fresh burst.
  task automatic test_single();
    int ep[8] = '{0, 1, 1, 1, 1, 0, 1, 0};
    int eb[8] = '{1, 1, 1, 1, 0, 1, 0, 0};
    int ex[8] = '{0, 10, 11, 12, 13, 13, 14, 14};
    do_reset();
    rem[0] = 5; nx[0] = 10;
    drive_inputs();
    for (int k = 0; k < 8; k++) begin
      cycle();
      n_run++;
      if (fifopush !== (ep[k] != 0) || busy !== (eb[k] != 0) || wr_x !== HW'(ex[k])) begin
        n_fail++;
        $display("FAIL single cyc %0d: got push=%0b busy=%0b x=%0d, want %0d %0d %0d",
                 k + 1, fifopush, busy, wr_x, ep[k], eb[k], ex[k]);
      end
      if (ep[k] != 0) begin
        n_run++;
        if (wr_y !== VW'(ex[k] + 3) || wr_rgb !== 3'(ex[k])) begin
          n_fail++;
          $display("FAIL single_yrgb cyc %0d: got y=%0d rgb=%0d, want %0d %0d",
                   k + 1, wr_y, wr_rgb, ex[k] + 3, ex[k] & 7);
        end
      end
    end
    n_run++;
    if (grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL single_gid: got %0d want 0", grant_id);
    end
  endtask

  // All three requesters continuously valid: bursts 0,1,2,0 of 4 beats, 1 idle cycle between.
  task automatic test_round_robin();
    int            base[3] = '{100, 200, 300};
    int            p, pos, r, off, xe;
    logic [NR-1:0] er;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      rem[i] = 100; nx[i] = base[i];
    end
    drive_inputs();
    for (int k = 1; k <= 20; k++) begin
      cycle();
      p   = (k - 1) / 5;
      pos = (k - 1) % 5;
      r   = (p == 3) ? 0 : p;
      off = (p == 3) ? 4 : 0;
      er  = (pos != 0) ? NR'(1 << r) : '0;
      n_run++;
      if (grant_id !== 2'(r) || fifopush !== (pos != 0) || rdy_s !== er) begin
        n_fail++;
        $display("FAIL rr cyc %0d: got gid=%0d push=%0b rdy=%b, want %0d %0b %b",
                 k, grant_id, fifopush, rdy_s, r, pos != 0, er);
      end
      if (pos != 0) begin
        xe = base[r] + off + pos - 1;
        n_run++;
        if (wr_x !== HW'(xe) || wr_y !== VW'(xe + 3)) begin
          n_fail++;
          $display("FAIL rr_data cyc %0d: got x=%0d y=%0d, want %0d %0d",
                   k, wr_x, wr_y, xe, xe + 3);
        end
      end
    end
  endtask

  // fifofull for 3 cycles after two beats: pause, same grant, beat count kept
  // (release still comes after the fourth beat overall).
  task automatic test_fifofull();
    int ep[10] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1};
    int eb[10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    int ex[10] = '{0, 20, 21, 21, 21, 21, 22, 23, 23, 24};
    do_reset();
    rem[0] = 6; nx[0] = 20;
    drive_inputs();
    for (int k = 1; k <= 10; k++) begin
      fifofull = (k >= 4 && k <= 6);
      cycle();
      n_run++;
      if (fifopush !== (ep[k-1] != 0) || busy !== (eb[k-1] != 0) ||
          wr_x !== HW'(ex[k-1]) || grant_id !== 2'd0) begin
        n_fail++;
        $display("FAIL full cyc %0d: got push=%0b busy=%0b x=%0d gid=%0d, want %0d %0d %0d 0",
                 k, fifopush, busy, wr_x, grant_id, ep[k-1], eb[k-1], ex[k-1]);
      end
      if (fifofull) begin
        n_run++;
        if (rdy_s !== 3'b000) begin
          n_fail++;
          $display("FAIL full_ready cyc %0d: got %b want 000", k, rdy_s);
        end
      end
    end
    fifofull = 1'b0;
  endtask

  // mem_en low for 2 cycles mid-burst: no pushes, no release, all 4 beats delivered.
  task automatic test_mem_en();
    int ep[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int eb[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int ex[8] = '{0, 40, 41, 41, 41, 42, 43, 43};
    do_reset();
    rem[0] = 4; nx[0] = 40;
    drive_inputs();
    for (int k = 1; k <= 8; k++) begin
      mem_en = !(k == 4 || k == 5);
      cycle();
      n_run++;
      if (fifopush !== (ep[k-1] != 0) || busy !== (eb[k-1] != 0) || wr_x !== HW'(ex[k-1])) begin
        n_fail++;
        $display("FAIL memen cyc %0d: got push=%0b busy=%0b x=%0d, want %0d %0d %0d",
                 k, fifopush, busy, wr_x, ep[k-1], eb[k-1], ex[k-1]);
      end
      if (!mem_en) begin
        n_run++;
        if (rdy_s !== 3'b000) begin
          n_fail++;
          $display("FAIL memen_ready cyc %0d: got %b want 000", k, rdy_s);
        end
      end
    end
    mem_en = 1'b1;
  endtask

  // req1 drops valid after two beats while req2 waits: release, then req2 granted.
  task automatic test_valid_drop();
    int ep[9] = '{0, 1, 1, 0, 0, 1, 1, 1, 0};
    int eb[9] = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
    int eg[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 2};
    int ex[9] = '{0, 50, 51, 51, 51, 60, 61, 62, 62};
    do_reset();
    rem[1] = 2; nx[1] = 50; nolast[1] = 1;
    rem[2] = 3; nx[2] = 60;
    drive_inputs();
    for (int k = 1; k <= 9; k++) begin
      cycle();
      n_run++;
      if (fifopush !== (ep[k-1] != 0) || busy !== (eb[k-1] != 0) ||
          grant_id !== 2'(eg[k-1]) || wr_x !== HW'(ex[k-1])) begin
        n_fail++;
        $display("FAIL drop cyc %0d: got push=%0b busy=%0b gid=%0d x=%0d, want %0d %0d %0d %0d",
                 k, fifopush, busy, grant_id, wr_x, ep[k-1], eb[k-1], eg[k-1], ex[k-1]);
      end
      if (k == 4) begin
        n_run++;
        if (rdy_s !== 3'b000) begin
          n_fail++;
          $display("FAIL drop_ready: got %b want 000", rdy_s);
        end
      end
    end
  endtask

  // Reset in the middle of a req1 burst (after rr moved to 0): outputs clear,
  // and arbitration restarts at req0 even though req1 is still valid.
  task automatic test_reset_mid_burst();
    int ep[5] = '{0, 1, 0, 1, 1};
    int eg[5] = '{0, 0, 1, 1, 1};
    int ex[5] = '{0, 70, 70, 80, 81};
    do_reset();
    rem[0] = 1;  nx[0] = 70;
    rem[1] = 10; nx[1] = 80;
    drive_inputs();
    for (int k = 1; k <= 5; k++) begin
      cycle();
      n_run++;
      if (fifopush !== (ep[k-1] != 0) || grant_id !== 2'(eg[k-1]) || wr_x !== HW'(ex[k-1])) begin
        n_fail++;
        $display("FAIL rstmid_pre cyc %0d: got push=%0b gid=%0d x=%0d, want %0d %0d %0d",
                 k, fifopush, grant_id, wr_x, ep[k-1], eg[k-1], ex[k-1]);
      end
    end
    rem[0] = 5;
    drive_inputs();
    reset = 1'b1;
    #1;
    n_run++;
    if ({fifopush, busy, wr_x, wr_y, wr_rgb, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got push=%0b busy=%0b x=%0d y=%0d rgb=%0d gid=%0d, want all 0",
               fifopush, busy, wr_x, wr_y, wr_rgb, grant_id);
    end
    cycle();
    n_run++;
    if (fifopush !== 1'b0 || busy !== 1'b0 || wr_x !== '0) begin
      n_fail++;
      $display("FAIL rstmid_hold: got push=%0b busy=%0b x=%0d, want 0 0 0", fifopush, busy, wr_x);
    end
    reset = 1'b0;
    cycle();
    n_run++;
    if (grant_id !== 2'd0 || busy !== 1'b1 || fifopush !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got gid=%0d busy=%0b push=%0b, want 0 1 0",
               grant_id, busy, fifopush);
    end
    cycle();
    n_run++;
    if (fifopush !== 1'b1 || wr_x !== HW'(71)) begin
      n_fail++;
      $display("FAIL rstmid_resume: got push=%0b x=%0d, want 1 71", fifopush, wr_x);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_fifofull();
    test_mem_en();
    test_valid_drop();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
